// File: rtl/rgb_led_ctrl_if.sv
// Register write port between the SoC I/O bus and the RGB LED controller.
// The master drives the write request; the slave answers with wr_ready.
interface rgb_led_ctrl_if #(
   parameter int unsigned PWM_BITS = 8
);
   logic                wr_en;
   logic [1:0]          wr_addr;
   logic [PWM_BITS-1:0] wr_data;
   logic                wr_ready;

   modport master (output wr_en, output wr_addr, output wr_data, input wr_ready);
   modport slave  (input wr_en, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/rgb_led_ctrl.sv
// RGB LED controller: per-channel PWM dimming with duty shadow registers
// and an optional blink pattern sequenced by a small FSM.
module rgb_led_ctrl #(
   parameter int unsigned PWM_BITS    = 8,
   parameter int unsigned BLINK_SHIFT = 14,
   parameter bit          ACTIVE_LOW  = 1'b1
) (
   input  logic           clk_48mhz,
   input  logic           reset,
   rgb_led_ctrl_if.slave  bus,
   output logic           led_r,
   output logic           led_g,
   output logic           led_b,
   output logic           pwm_wrap,
   output logic           blink_phase
);
   localparam int unsigned BCNT_W = BLINK_SHIFT + 4;
   localparam logic [PWM_BITS-1:0] CNT_PRE = {{(PWM_BITS-1){1'b1}}, 1'b0};

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_SOLID   = 2'd1,
      S_BLK_ON  = 2'd2,
      S_BLK_OFF = 2'd3
   } state_e;

   state_e              state_q, state_d;
   logic [BCNT_W-1:0]   bcnt_q, bcnt_d, limit_c;
   logic [PWM_BITS-1:0] cnt_q;
   logic [PWM_BITS-1:0] sh_r_q, sh_g_q, sh_b_q;
   logic [PWM_BITS-1:0] act_r_q, act_g_q, act_b_q;
   logic [3:0]          ctrl_q;
   logic                wrap_q, rdy_q, bphase_q;
   logic                led_r_q, led_g_q, led_b_q;
   logic                accept_c, lit_c, enable_c, blink_c;
   logic [1:0]          rate_c;

   assign accept_c = bus.wr_en && rdy_q;
   assign enable_c = ctrl_q[0];
   assign blink_c  = ctrl_q[1];
   assign rate_c   = ctrl_q[3:2];
   assign lit_c    = (state_q == S_SOLID) || (state_q == S_BLK_ON);
   assign limit_c  = (BCNT_W'(1) << (BLINK_SHIFT + 32'(rate_c))) - BCNT_W'(1);

   // Next-state and blink counter; '>=' lets a lowered limit toggle at the next wrap
   always_comb begin
      state_d = state_q;
      bcnt_d  = bcnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (enable_c) begin
               state_d = blink_c ? S_BLK_ON : S_SOLID;
               bcnt_d  = '0;
            end
         end
         S_SOLID: begin
            if (!enable_c) begin
               state_d = S_IDLE;
            end else if (blink_c) begin
               state_d = S_BLK_ON;
               bcnt_d  = '0;
            end
         end
         S_BLK_ON, S_BLK_OFF: begin
            if (!enable_c) begin
               state_d = S_IDLE;
            end else if (!blink_c) begin
               state_d = S_SOLID;
            end else if (wrap_q) begin
               if (bcnt_q >= limit_c) begin
                  state_d = (state_q == S_BLK_ON) ? S_BLK_OFF : S_BLK_ON;
                  bcnt_d  = '0;
               end else if (bcnt_q != {BCNT_W{1'b1}}) begin
                  bcnt_d = bcnt_q + BCNT_W'(1);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_48mhz) begin
      if (reset) begin
         state_q  <= S_IDLE;
         bcnt_q   <= '0;
         cnt_q    <= '0;
         wrap_q   <= 1'b0;
         rdy_q    <= 1'b0;
         ctrl_q   <= '0;
         sh_r_q   <= '0;
         sh_g_q   <= '0;
         sh_b_q   <= '0;
         act_r_q  <= '0;
         act_g_q  <= '0;
         act_b_q  <= '0;
         bphase_q <= 1'b1;
         led_r_q  <= ACTIVE_LOW;
         led_g_q  <= ACTIVE_LOW;
         led_b_q  <= ACTIVE_LOW;
      end else begin
         state_q  <= state_d;
         bcnt_q   <= bcnt_d;
         cnt_q    <= cnt_q + PWM_BITS'(1);
         wrap_q   <= (cnt_q == CNT_PRE);
         rdy_q    <= 1'b1;
         bphase_q <= (state_d != S_BLK_OFF);
         if (accept_c) begin
            unique case (bus.wr_addr)
               2'd0: sh_r_q <= bus.wr_data;
               2'd1: sh_g_q <= bus.wr_data;
               2'd2: sh_b_q <= bus.wr_data;
               2'd3: ctrl_q <= bus.wr_data[3:0];
               default: ;
            endcase
         end
         // Shadow copied with pre-write values, so a write on the wrap cycle waits a period
         if (wrap_q) begin
            act_r_q <= sh_r_q;
            act_g_q <= sh_g_q;
            act_b_q <= sh_b_q;
         end
         led_r_q <= ((cnt_q < act_r_q) && lit_c) ^ ACTIVE_LOW;
         led_g_q <= ((cnt_q < act_g_q) && lit_c) ^ ACTIVE_LOW;
         led_b_q <= ((cnt_q < act_b_q) && lit_c) ^ ACTIVE_LOW;
      end
   end

   assign bus.wr_ready = rdy_q;
   assign led_r        = led_r_q;
   assign led_g        = led_g_q;
   assign led_b        = led_b_q;
   assign pwm_wrap     = wrap_q;
   assign blink_phase  = bphase_q;
endmodule

// File: tb/tb_rgb_led_ctrl.sv
// Self-checking bench for rgb_led_ctrl: table-driven PWM duty vectors with a
// pattern scoreboard, plus hand sequences for wrap-aligned writes, blink and reset.
module tb_rgb_led_ctrl;
   localparam int unsigned PWM_BITS    = 4;
   localparam int unsigned BLINK_SHIFT = 1;

   logic clk = 1'b0;
   logic reset;
   logic led_r, led_g, led_b, pwm_wrap, blink_phase;

   always #5 clk = ~clk;

   rgb_led_ctrl_if #(.PWM_BITS(PWM_BITS)) bus_if ();

   rgb_led_ctrl #(
      .PWM_BITS   (PWM_BITS),
      .BLINK_SHIFT(BLINK_SHIFT),
      .ACTIVE_LOW (1'b1)
   ) dut (
      .clk_48mhz  (clk),
      .reset      (reset),
      .bus        (bus_if),
      .led_r      (led_r),
      .led_g      (led_g),
      .led_b      (led_b),
      .pwm_wrap   (pwm_wrap),
      .blink_phase(blink_phase)
   );

   typedef struct {
      logic [3:0]  dr, dg, db, ctrl;
      logic [15:0] er, eg, eb;   // bit i = channel lit while cnt == i
   } vec_t;

   vec_t        vecs[5];
   logic [47:0] sb_q[$];
   int          checks   = 0;
   int          failures = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic wr(input logic [1:0] a, input logic [3:0] d);
      bus_if.wr_en   = 1'b1;
      bus_if.wr_addr = a;
      bus_if.wr_data = d;
      tick();
      bus_if.wr_en   = 1'b0;
   endtask

   // Advance until the cycle in which pwm_wrap is high (cnt == max)
   task automatic wait_wrap(input string tag);
      int n = 0;
      do begin
         tick();
         n++;
      end while (!pwm_wrap && n < 40);
      check({tag, "_wrap_seen"}, 32'(pwm_wrap), 32'd1);
   endtask

   // Starts in a cnt==0 cycle; sample k reflects cnt==k of this period
   task automatic measure(input string tag);
      logic [15:0] r, g, b;
      logic [47:0] e;
      for (int i = 0; i < 16; i++) begin
         tick();
         r[i] = !led_r;
         g[i] = !led_g;
         b[i] = !led_b;
      end
      if (sb_q.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL %s scoreboard empty actual=%0h_%0h_%0h", tag, r, g, b);
      end else begin
         e = sb_q.pop_front();
         check({tag, "_r"}, 32'(r), 32'(e[47:32]));
         check({tag, "_g"}, 32'(g), 32'(e[31:16]));
         check({tag, "_b"}, 32'(b), 32'(e[15:0]));
      end
   endtask

   initial begin
      int n;
      int lows;
      logic bp;

      vecs[0] = '{dr:4'd4,  dg:4'd0, db:4'd0,  ctrl:4'd1, er:16'h000F, eg:16'h0000, eb:16'h0000};
      vecs[1] = '{dr:4'd0,  dg:4'd8, db:4'd15, ctrl:4'd1, er:16'h0000, eg:16'h00FF, eb:16'h7FFF};
      vecs[2] = '{dr:4'd15, dg:4'd1, db:4'd2,  ctrl:4'd1, er:16'h7FFF, eg:16'h0001, eb:16'h0003};
      vecs[3] = '{dr:4'd9,  dg:4'd9, db:4'd9,  ctrl:4'd0, er:16'h0000, eg:16'h0000, eb:16'h0000};
      vecs[4] = '{dr:4'd3,  dg:4'd5, db:4'd7,  ctrl:4'd1, er:16'h0007, eg:16'h001F, eb:16'h007F};

      reset          = 1'b1;
      bus_if.wr_en   = 1'b0;
      bus_if.wr_addr = 2'd0;
      bus_if.wr_data = 4'd0;

      // Reset state
      repeat (3) tick();
      check("rst_pins", 32'({led_r, led_g, led_b}), 32'h7);
      check("rst_blink_phase", 32'(blink_phase), 32'd1);
      check("rst_wr_ready", 32'(bus_if.wr_ready), 32'd0);
      check("rst_pwm_wrap", 32'(pwm_wrap), 32'd0);
      reset = 1'b0;
      #1;
      check("rel_wr_ready_low", 32'(bus_if.wr_ready), 32'd0);
      tick();
      check("rel_wr_ready_high", 32'(bus_if.wr_ready), 32'd1);

      // Table-driven duty vectors
      foreach (vecs[i]) begin
         wr(2'd0, vecs[i].dr);
         wr(2'd1, vecs[i].dg);
         wr(2'd2, vecs[i].db);
         wr(2'd3, vecs[i].ctrl);
         sb_q.push_back({vecs[i].er, vecs[i].eg, vecs[i].eb});
         wait_wrap($sformatf("vec%0d", i));
         tick();
         measure($sformatf("vec%0d", i));
      end

      // Mid-period DUTY_R write: old duty 3 persists until the wrap
      wr(2'd0, 4'd12);
      lows = 0;
      for (int i = 0; i < 14; i++) begin
         tick();
         if (!led_r) lows++;
      end
      check("r_hold_lows", 32'(lows), 32'd2);
      check("r_hold_wrap", 32'(pwm_wrap), 32'd1);
      sb_q.push_back({16'h0FFF, 16'h001F, 16'h007F});
      tick();
      measure("r_new");

      // Write on the pwm_wrap cycle lands one period late
      wr(2'd0, 4'd0);
      wr(2'd1, 4'd0);
      wr(2'd2, 4'd0);
      wait_wrap("g_pre");
      wr(2'd1, 4'd8);
      sb_q.push_back({16'h0000, 16'h0000, 16'h0000});
      measure("g_same_wrap");
      sb_q.push_back({16'h0000, 16'h00FF, 16'h0000});
      measure("g_next_wrap");

      // Two writes in one period: the last one wins
      wait_wrap("b_pre");
      wr(2'd2, 4'd3);
      wr(2'd2, 4'd9);
      sb_q.push_back({16'h0000, 16'h00FF, 16'h01FF});
      wait_wrap("b_last");
      tick();
      measure("b_last");

      // Blink at rate 0: 2 PWM periods per half
      wr(2'd1, 4'd0);
      wr(2'd2, 4'd15);
      wr(2'd3, 4'b0011);
      n = 0;
      while (blink_phase && n < 200) begin tick(); n++; end
      n = 0;
      lows = 0;
      while (!blink_phase && n < 200) begin
         if (!led_b) lows++;
         tick();
         n++;
      end
      check("blink_off_len", 32'(n), 32'd32);
      check("blink_off_b_lit", 32'(lows), 32'd0);
      n = 0;
      while (blink_phase && n < 200) begin tick(); n++; end
      check("blink_on_len", 32'(n), 32'd32);

      // Rate 2: 8 PWM periods per half
      wr(2'd3, 4'b1011);
      bp = blink_phase;
      n = 0;
      while (blink_phase == bp && n < 300) begin tick(); n++; end
      bp = blink_phase;
      n = 0;
      while (blink_phase == bp && n < 300) begin tick(); n++; end
      check("blink_rate2_len", 32'(n), 32'd128);

      // Reset in the middle of BLK_ON
      n = 0;
      while (!blink_phase && n < 300) begin tick(); n++; end
      repeat (5) tick();
      reset = 1'b1;
      tick();
      check("mid_rst_pins", 32'({led_r, led_g, led_b}), 32'h7);
      check("mid_rst_blink_phase", 32'(blink_phase), 32'd1);
      check("mid_rst_wr_ready", 32'(bus_if.wr_ready), 32'd0);
      reset = 1'b0;
      tick();
      check("post_rst_wr_ready", 32'(bus_if.wr_ready), 32'd1);
      wr(2'd3, 4'd1);
      sb_q.push_back({16'h0000, 16'h0000, 16'h0000});
      wait_wrap("post_rst");
      tick();
      measure("post_rst");
      check("post_rst_blink_phase", 32'(blink_phase), 32'd1);
      check("sb_drained", 32'(sb_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
